// File: rtl/ex_pkg.sv
// ex_pkg: definitions shared by the EX dispatch slice.
//   - chip-select encodings produced by the EX decoder
//   - opcode widths of the ALU, MDU and BMU control fields
//   - dispatcher FSM state encoding
package ex_pkg;

  localparam logic [1:0] CS_ALU = 2'b00;
  localparam logic [1:0] CS_MDU = 2'b01;
  localparam logic [1:0] CS_BMU = 2'b10;
  localparam logic [1:0] CS_FPU = 2'b11;

  localparam int ALU_OP_W = 4;
  localparam int MDU_OP_W = 3;
  localparam int BMU_OP_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } disp_state_e;

endpackage

// File: rtl/ex_mdu_cache.sv
// ex_mdu_cache: single-entry memo of the last completed MDU operation.
// Lookup is combinational against the incoming instruction's {op, a, b};
// a store overwrites the entry and sets its valid bit.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   lookup_op/a/b  -> hit, hit_data   compare of the candidate operation
//   store_en, store_op/a/b/data       write of a completed operation
module ex_mdu_cache
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MDU_OP_W-1:0] lookup_op,
  input  logic [XLEN-1:0]     lookup_a,
  input  logic [XLEN-1:0]     lookup_b,
  output logic                hit,
  output logic [XLEN-1:0]     hit_data,
  input  logic                store_en,
  input  logic [MDU_OP_W-1:0] store_op,
  input  logic [XLEN-1:0]     store_a,
  input  logic [XLEN-1:0]     store_b,
  input  logic [XLEN-1:0]     store_data
);

  logic                valid_q, valid_d;
  logic [MDU_OP_W-1:0] op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [XLEN-1:0]     data_q, data_d;

  assign hit      = valid_q && (lookup_op == op_q) && (lookup_a == a_q) && (lookup_b == b_q);
  assign hit_data = data_q;

  // Entry holds until the next completed operation replaces it.
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    if (store_en) begin
      valid_d = 1'b1;
      op_d    = store_op;
      a_d     = store_a;
      b_d     = store_b;
      data_d  = store_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/ex_dispatch.sv
// ex_dispatch: routes decoded EX instructions to the ALU, BMU or MDU and
// registers the selected result toward writeback.
//   - ALU/BMU: combinational units, result captured in the accept cycle.
//   - MDU: multi-cycle unit behind a valid/ready request and a response
//     pulse; issue stalls (in_ready=0) until the response returns.
//   - FPU select: accepted, answered with a one-cycle illegal_op pulse.
//   - flush kills the in-flight MDU op (response consumed, no writeback)
//     and masks a result that is being emitted in the same cycle.
// Optional build macro EX_MDU_RESULT_CACHE_EN adds a one-entry MDU result
// cache (ex_mdu_cache) that completes repeated MDU ops without a request.
// Ports:
//   clk, rst                                clock, synchronous active-high reset
//   in_valid/in_ready, in_cs, in_*_op,
//   in_rs1/in_rs2, in_rd, flush             decoded instruction input
//   alu_op/a/b, alu_result                  ALU interface
//   bmu_op/a/b, bmu_result                  BMU interface
//   mdu_req_*, mdu_resp_*                   MDU request/response
//   out_valid/out_data/out_rd               writeback
//   illegal_op                              FPU select pulse
module ex_dispatch
  import ex_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_cs,
  input  logic [ALU_OP_W-1:0] in_alu_op,
  input  logic [MDU_OP_W-1:0] in_mdu_op,
  input  logic [BMU_OP_W-1:0] in_bmu_op,
  input  logic [XLEN-1:0]     in_rs1,
  input  logic [XLEN-1:0]     in_rs2,
  input  logic [RD_W-1:0]     in_rd,
  input  logic                flush,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [XLEN-1:0]     alu_a,
  output logic [XLEN-1:0]     alu_b,
  input  logic [XLEN-1:0]     alu_result,
  output logic [BMU_OP_W-1:0] bmu_op,
  output logic [XLEN-1:0]     bmu_a,
  output logic [XLEN-1:0]     bmu_b,
  input  logic [XLEN-1:0]     bmu_result,
  output logic                mdu_req_valid,
  input  logic                mdu_req_ready,
  output logic [MDU_OP_W-1:0] mdu_req_op,
  output logic [XLEN-1:0]     mdu_req_a,
  output logic [XLEN-1:0]     mdu_req_b,
  input  logic                mdu_resp_valid,
  input  logic [XLEN-1:0]     mdu_resp_data,
  output logic                out_valid,
  output logic [XLEN-1:0]     out_data,
  output logic [RD_W-1:0]     out_rd,
  output logic                illegal_op
);

  disp_state_e         state_q, state_d;
  logic                kill_q, kill_d;
  logic [MDU_OP_W-1:0] op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [RD_W-1:0]     rd_q, rd_d;
  logic                out_valid_q, out_valid_d;
  logic [XLEN-1:0]     out_data_q, out_data_d;
  logic [RD_W-1:0]     out_rd_q, out_rd_d;
  logic                illegal_q, illegal_d;

  logic                accept;
  logic                sel_alu;
  logic                sel_bmu;
  logic                cache_hit;
  logic [XLEN-1:0]     cache_data;
  logic                cache_store;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready && !flush;
  assign sel_alu  = in_valid && (in_cs == CS_ALU);
  assign sel_bmu  = in_valid && (in_cs == CS_BMU);

  // Operands reach a combinational unit only when it is the selected one,
  // so an FPU select or an MDU op leaves the ALU/BMU inputs quiet.
  assign alu_op = in_alu_op;
  assign alu_a  = sel_alu ? in_rs1 : '0;
  assign alu_b  = sel_alu ? in_rs2 : '0;
  assign bmu_op = sel_bmu ? in_bmu_op : '0;
  assign bmu_a  = sel_bmu ? in_rs1 : '0;
  assign bmu_b  = sel_bmu ? in_rs2 : '0;

  // The request payload comes from the latched copy, so it stays stable
  // for however long the MDU holds off ready.
  assign mdu_req_valid = (state_q == ISSUE);
  assign mdu_req_op    = mdu_req_valid ? op_q : '0;
  assign mdu_req_a     = mdu_req_valid ? a_q : '0;
  assign mdu_req_b     = mdu_req_valid ? b_q : '0;

  // A flush arriving in the emit cycle kills the result being written back.
  assign out_valid  = out_valid_q && !flush;
  assign out_data   = out_data_q;
  assign out_rd     = out_rd_q;
  assign illegal_op = illegal_q;

`ifdef EX_MDU_RESULT_CACHE_EN
  ex_mdu_cache #(
    .XLEN(XLEN)
  ) u_mdu_cache (
    .clk       (clk),
    .rst       (rst),
    .lookup_op (in_mdu_op),
    .lookup_a  (in_rs1),
    .lookup_b  (in_rs2),
    .hit       (cache_hit),
    .hit_data  (cache_data),
    .store_en  (cache_store),
    .store_op  (op_q),
    .store_a   (a_q),
    .store_b   (b_q),
    .store_data(mdu_resp_data)
  );
`else
  logic unused_cache_store;
  assign unused_cache_store = cache_store;
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  // Next-state and writeback selection. A request is never withdrawn once
  // raised; a flush during ISSUE/WAIT only marks the op killed so that its
  // response is swallowed. Responses seen outside WAIT are ignored.
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_d        = rd_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_rd_d    = out_rd_q;
    illegal_d   = 1'b0;
    cache_store = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (in_cs)
            CS_ALU: begin
              out_valid_d = 1'b1;
              out_data_d  = alu_result;
              out_rd_d    = in_rd;
            end
            CS_BMU: begin
              out_valid_d = 1'b1;
              out_data_d  = bmu_result;
              out_rd_d    = in_rd;
            end
            CS_MDU: begin
              if (cache_hit) begin
                out_valid_d = 1'b1;
                out_data_d  = cache_data;
                out_rd_d    = in_rd;
              end else begin
                op_d    = in_mdu_op;
                a_d     = in_rs1;
                b_d     = in_rs2;
                rd_d    = in_rd;
                state_d = ISSUE;
              end
            end
            default: begin
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      ISSUE: begin
        if (flush) begin
          kill_d = 1'b1;
        end
        if (mdu_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          kill_d = 1'b1;
        end
        if (mdu_resp_valid) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          if (!(kill_q || flush)) begin
            out_valid_d = 1'b1;
            out_data_d  = mdu_resp_data;
            out_rd_d    = rd_q;
            cache_store = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      kill_q      <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_rd_q    <= out_rd_d;
      illegal_q   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_ex_dispatch.sv
// tb_ex_dispatch: self-checking bench for ex_dispatch.
// The bench plays the ALU (a+b), the BMU (a-b+op) and a multi-cycle MDU
// with randomised ready/response timing. A transaction-level model predicts
// writeback, stall and request behaviour every cycle; directed sequences
// pin the model with hand-computed values. Build with EX_MDU_RESULT_CACHE_EN
// to also cover the result cache.
`timescale 1ns/1ps
module tb_ex_dispatch;
  import ex_pkg::*;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [1:0]          in_cs = '0;
  logic [ALU_OP_W-1:0] in_alu_op = '0;
  logic [MDU_OP_W-1:0] in_mdu_op = '0;
  logic [BMU_OP_W-1:0] in_bmu_op = '0;
  logic [XLEN-1:0]     in_rs1 = '0;
  logic [XLEN-1:0]     in_rs2 = '0;
  logic [RD_W-1:0]     in_rd = '0;
  logic                flush = 1'b0;
  logic [ALU_OP_W-1:0] alu_op;
  logic [XLEN-1:0]     alu_a, alu_b, alu_result;
  logic [BMU_OP_W-1:0] bmu_op;
  logic [XLEN-1:0]     bmu_a, bmu_b, bmu_result;
  logic                mdu_req_valid;
  logic                mdu_req_ready = 1'b0;
  logic [MDU_OP_W-1:0] mdu_req_op;
  logic [XLEN-1:0]     mdu_req_a, mdu_req_b;
  logic                mdu_resp_valid = 1'b0;
  logic [XLEN-1:0]     mdu_resp_data = '0;
  logic                out_valid;
  logic [XLEN-1:0]     out_data;
  logic [RD_W-1:0]     out_rd;
  logic                illegal_op;

  assign alu_result = alu_a + alu_b;
  assign bmu_result = bmu_a - bmu_b + XLEN'(bmu_op);

  ex_dispatch #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cs(in_cs),
    .in_alu_op(in_alu_op), .in_mdu_op(in_mdu_op), .in_bmu_op(in_bmu_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .flush(flush),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .bmu_op(bmu_op), .bmu_a(bmu_a), .bmu_b(bmu_b), .bmu_result(bmu_result),
    .mdu_req_valid(mdu_req_valid), .mdu_req_ready(mdu_req_ready), .mdu_req_op(mdu_req_op),
    .mdu_req_a(mdu_req_a), .mdu_req_b(mdu_req_b), .mdu_resp_valid(mdu_resp_valid),
    .mdu_resp_data(mdu_resp_data), .out_valid(out_valid), .out_data(out_data),
    .out_rd(out_rd), .illegal_op(illegal_op)
  );

  int n_compared = 0;
  int n_mismatched = 0;

  // Stimulus knobs for the next cycle.
  logic                s_rst = 1'b1, s_valid = 1'b0, s_flush = 1'b0, s_ready = 1'b0, s_spur = 1'b0;
  logic [1:0]          s_cs = '0;
  logic [ALU_OP_W-1:0] s_alu_op = '0;
  logic [MDU_OP_W-1:0] s_mdu_op = '0;
  logic [BMU_OP_W-1:0] s_bmu_op = '0;
  logic [XLEN-1:0]     s_rs1 = '0, s_rs2 = '0;
  logic [RD_W-1:0]     s_rd = '0;
  int                  s_delay = -1;

  // Model: pending writeback, outstanding MDU op, bench-side MDU, cache.
  logic                live = 1'b0;
  logic                p_valid = 1'b0, p_illegal = 1'b0;
  logic [XLEN-1:0]     p_data = '0;
  logic [RD_W-1:0]     p_rd = '0;
  logic                m_req = 1'b0, m_wait = 1'b0, m_kill = 1'b0;
  logic [MDU_OP_W-1:0] m_op = '0, cap_op = '0;
  logic [XLEN-1:0]     m_a = '0, m_b = '0, cap_a = '0, cap_b = '0;
  logic [RD_W-1:0]     m_rd = '0;
  int                  resp_cnt = 0;
  logic                c_valid = 1'b0;
  logic [MDU_OP_W-1:0] c_op = '0;
  logic [XLEN-1:0]     c_a = '0, c_b = '0, c_res = '0;

  function automatic logic [XLEN-1:0] mdu_fn(input logic [MDU_OP_W-1:0] op,
                                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (op)
      3'd0:    return a * b;
      3'd4:    return (b == 0) ? {XLEN{1'b1}} : a / b;
      3'd6:    return (b == 0) ? a : a % b;
      default: return a + b + XLEN'(op);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [XLEN-1:0] actual, input logic [XLEN-1:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0b, expected %0b at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model by one edge.
  task automatic compareAndAdvance();
    logic ready_now, exp_ov, accept, hit;
    ready_now = !(m_req || m_wait);
    exp_ov    = p_valid && !flush;
    if (live) begin
      checkBit("in_ready", in_ready, ready_now);
      checkBit("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        checkOutput("out_data", out_data, p_data);
        checkOutput("out_rd", XLEN'(out_rd), XLEN'(p_rd));
      end
      checkBit("illegal_op", illegal_op, p_illegal);
      checkBit("mdu_req_valid", mdu_req_valid, m_req);
      if (m_req) begin
        checkOutput("mdu_req_op", XLEN'(mdu_req_op), XLEN'(m_op));
        checkOutput("mdu_req_a", mdu_req_a, m_a);
        checkOutput("mdu_req_b", mdu_req_b, m_b);
      end
      checkOutput("alu_op", XLEN'(alu_op), XLEN'(in_alu_op));
    end
    p_valid   = 1'b0;
    p_illegal = 1'b0;
    if (rst) begin
      live = 1'b1; m_req = 1'b0; m_wait = 1'b0; m_kill = 1'b0;
      p_data = '0; p_rd = '0; c_valid = 1'b0; resp_cnt = 0;
      return;
    end
    accept = in_valid && ready_now && !flush;
    if (m_req) begin
      if (flush) m_kill = 1'b1;
      if (mdu_req_ready) begin
        m_req = 1'b0; m_wait = 1'b1;
        cap_op = mdu_req_op; cap_a = mdu_req_a; cap_b = mdu_req_b;
        resp_cnt = (s_delay < 0) ? int'($urandom_range(0, 3)) : s_delay;
      end
    end else if (m_wait) begin
      if (flush) m_kill = 1'b1;
      if (mdu_resp_valid) begin
        m_wait = 1'b0;
        if (!m_kill) begin
          p_valid = 1'b1; p_data = mdu_fn(m_op, m_a, m_b); p_rd = m_rd;
          c_valid = 1'b1; c_op = m_op; c_a = m_a; c_b = m_b; c_res = p_data;
        end
        m_kill = 1'b0;
      end
    end
    if (accept) begin
      case (in_cs)
        CS_ALU: begin p_valid = 1'b1; p_data = in_rs1 + in_rs2; p_rd = in_rd; end
        CS_BMU: begin p_valid = 1'b1; p_data = in_rs1 - in_rs2 + XLEN'(in_bmu_op); p_rd = in_rd; end
        CS_FPU: p_illegal = 1'b1;
        default: begin
`ifdef EX_MDU_RESULT_CACHE_EN
          hit = c_valid && (c_op == in_mdu_op) && (c_a == in_rs1) && (c_b == in_rs2);
`else
          hit = 1'b0;
`endif
          if (hit) begin
            p_valid = 1'b1; p_data = c_res; p_rd = in_rd;
          end else begin
            m_req = 1'b1; m_op = in_mdu_op; m_a = in_rs1; m_b = in_rs2; m_rd = in_rd;
          end
        end
      endcase
    end
  endtask

  // Drives one cycle of inputs (plus the bench MDU's response), then checks.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    rst = s_rst; in_valid = s_valid; in_cs = s_cs; in_alu_op = s_alu_op;
    in_mdu_op = s_mdu_op; in_bmu_op = s_bmu_op; in_rs1 = s_rs1; in_rs2 = s_rs2;
    in_rd = s_rd; flush = s_flush; mdu_req_ready = s_ready;
    if (m_wait && resp_cnt == 0) begin
      mdu_resp_valid = 1'b1;
      mdu_resp_data  = mdu_fn(cap_op, cap_a, cap_b);
    end else begin
      if (m_wait) resp_cnt--;
      mdu_resp_valid = !m_wait && s_spur;
      mdu_resp_data  = $urandom;
    end
    @(negedge clk);
    compareAndAdvance();
  endtask

  task automatic setInstr(input logic [1:0] cs, input logic [MDU_OP_W-1:0] mop,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [RD_W-1:0] rd);
    s_valid = 1'b1; s_cs = cs; s_mdu_op = mop; s_rs1 = a; s_rs2 = b; s_rd = rd;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    s_valid = 1'b0; s_flush = 1'b0; s_ready = 1'b1; s_spur = 1'b0;
    while ((m_req || m_wait) && budget < 30) begin
      applyStimulus();
      budget++;
    end
    n_compared++;
    if (m_req || m_wait) begin
      n_mismatched++;
      $display("[TB] FAIL drain_timeout: MDU op still outstanding after %0d cycles", budget);
    end
    applyStimulus();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pulses, seen, k;
    logic done;

    // Reset
    s_rst = 1'b1;
    applyStimulus();
    applyStimulus();
    checkBit("rst_in_ready", in_ready, 1'b1);
    checkBit("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkBit("rst_illegal", illegal_op, 1'b0);
    checkBit("rst_req_valid", mdu_req_valid, 1'b0);
    s_rst = 1'b0;

    // ALU ADD 5+7 -> 12 to rd 3
    setInstr(CS_ALU, 3'd0, 32'd5, 32'd7, 5'd3);
    applyStimulus();
    s_valid = 1'b0;
    applyStimulus();
    checkBit("alu_add_valid", out_valid, 1'b1);
    checkOutput("alu_add_data", out_data, 32'd12);
    checkOutput("alu_add_rd", XLEN'(out_rd), 32'd3);

    // Four back-to-back ALU ops
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      setInstr(CS_ALU, 3'd0, XLEN'(i), 32'd10, RD_W'(i + 1));
      applyStimulus();
      pulses += int'(out_valid);
    end
    s_valid = 1'b0;
    applyStimulus();
    pulses += int'(out_valid);
    checkOutput("alu_b2b_pulses", XLEN'(pulses), 32'd4);

    // MDU MUL 6*7 with ready held off two cycles, response after four
    setInstr(CS_MDU, 3'd0, 32'd6, 32'd7, 5'd9);
    s_ready = 1'b0;
    applyStimulus();
    setInstr(CS_ALU, 3'd0, 32'd1, 32'd1, 5'd1);
    applyStimulus();
    checkBit("mul_stall_issue0", in_ready, 1'b0);
    applyStimulus();
    checkBit("mul_stall_issue1", in_ready, 1'b0);
    s_ready = 1'b1; s_delay = 3;
    applyStimulus();
    checkBit("mul_stall_handshake", in_ready, 1'b0);
    s_ready = 1'b0;
    done = 1'b0;
    for (k = 0; k < 12 && !done; k++) begin
      applyStimulus();
      if (out_valid) begin
        done = 1'b1;
        checkOutput("mul_data", out_data, 32'd42);
        checkOutput("mul_rd", XLEN'(out_rd), 32'd9);
        checkBit("mul_ready_on_out", in_ready, 1'b1);
      end else begin
        checkBit("mul_stall_wait", in_ready, 1'b0);
      end
    end
    checkBit("mul_completed", done, 1'b1);
    s_valid = 1'b0;
    applyStimulus();

    // DIV 100/7 flushed while waiting for the response
    setInstr(CS_DIV_CS(), 3'd4, 32'd100, 32'd7, 5'd4);
    s_ready = 1'b1; s_delay = 3;
    applyStimulus();
    s_valid = 1'b0;
    applyStimulus();
    applyStimulus();
    s_flush = 1'b1;
    applyStimulus();
    s_flush = 1'b0;
    seen = 0;
    for (k = 0; k < 10 && m_wait; k++) begin
      applyStimulus();
      seen += int'(out_valid);
      if (mdu_resp_valid) checkOutput("div_resp_value", mdu_resp_data, 32'd14);
    end
    applyStimulus();
    seen += int'(out_valid);
    checkOutput("flush_wait_no_out", XLEN'(seen), 32'd0);
    setInstr(CS_ALU, 3'd0, 32'd1, 32'd2, 5'd5);
    applyStimulus();
    s_valid = 1'b0;
    applyStimulus();
    checkBit("after_flush_alu_valid", out_valid, 1'b1);
    checkOutput("after_flush_alu_data", out_data, 32'd3);

    // MUL 3*3 flushed in ISSUE while ready is low
    setInstr(CS_MDU, 3'd0, 32'd3, 32'd3, 5'd6);
    s_ready = 1'b0; s_delay = 0;
    applyStimulus();
    s_valid = 1'b0; s_flush = 1'b1;
    applyStimulus();
    checkBit("flush_issue_req_held", mdu_req_valid, 1'b1);
    s_flush = 1'b0;
    for (k = 0; k < 3; k++) begin
      applyStimulus();
      checkBit("flush_issue_req_held", mdu_req_valid, 1'b1);
    end
    s_ready = 1'b1;
    applyStimulus();
    s_ready = 1'b0;
    seen = 0;
    for (k = 0; k < 6; k++) begin
      applyStimulus();
      seen += int'(out_valid);
    end
    checkOutput("flush_issue_no_out", XLEN'(seen), 32'd0);

    // FPU select
    setInstr(CS_FPU, 3'd0, 32'd1, 32'd2, 5'd7);
    applyStimulus();
    s_valid = 1'b0;
    applyStimulus();
    checkBit("fpu_illegal", illegal_op, 1'b1);
    checkBit("fpu_no_out", out_valid, 1'b0);
    checkBit("fpu_no_req", mdu_req_valid, 1'b0);
    applyStimulus();
    checkBit("fpu_illegal_pulse", illegal_op, 1'b0);

`ifdef EX_MDU_RESULT_CACHE_EN
    // REM 17,5 through the MDU, then from the cache, then through the MDU after reset
    setInstr(CS_MDU, 3'd6, 32'd17, 32'd5, 5'd8);
    s_ready = 1'b1; s_delay = 1;
    applyStimulus();
    s_valid = 1'b0;
    done = 1'b0;
    for (k = 0; k < 10 && !done; k++) begin
      applyStimulus();
      if (out_valid) begin
        done = 1'b1;
        checkOutput("rem_mdu_data", out_data, 32'd2);
      end
    end
    checkBit("rem_mdu_completed", done, 1'b1);
    setInstr(CS_MDU, 3'd6, 32'd17, 32'd5, 5'd8);
    applyStimulus();
    s_valid = 1'b0;
    applyStimulus();
    checkBit("rem_cache_valid", out_valid, 1'b1);
    checkOutput("rem_cache_data", out_data, 32'd2);
    checkBit("rem_cache_no_req", mdu_req_valid, 1'b0);
    checkBit("rem_cache_ready", in_ready, 1'b1);
    s_rst = 1'b1;
    applyStimulus();
    s_rst = 1'b0;
    setInstr(CS_MDU, 3'd6, 32'd17, 32'd5, 5'd8);
    s_ready = 1'b0;
    applyStimulus();
    s_valid = 1'b0;
    applyStimulus();
    checkBit("rem_after_rst_req", mdu_req_valid, 1'b1);
    checkBit("rem_after_rst_no_out", out_valid, 1'b0);
    drain();
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 2000; i++) begin
      s_rst    = ($urandom_range(0, 199) == 0);
      s_valid  = ($urandom_range(0, 9) < 7);
      s_cs     = 2'($urandom_range(0, 3));
      s_alu_op = ALU_OP_W'($urandom);
      s_bmu_op = BMU_OP_W'($urandom);
      s_mdu_op = ($urandom_range(0, 1) == 1) ? 3'd6 : MDU_OP_W'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        s_rs1 = XLEN'($urandom_range(0, 1));
        s_rs2 = XLEN'($urandom_range(0, 1));
      end else begin
        s_rs1 = $urandom;
        s_rs2 = $urandom;
      end
      s_rd    = RD_W'($urandom);
      s_flush = ($urandom_range(0, 9) == 0);
      s_ready = ($urandom_range(0, 1) == 1);
      s_spur  = ($urandom_range(0, 4) == 0);
      s_delay = -1;
      applyStimulus();
    end
    s_rst = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  function automatic logic [1:0] CS_DIV_CS();
    return CS_MDU;
  endfunction

endmodule
